// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU receive path: FSM encodings and protocol constants.
package modbus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDrain,
        StHold
    } rx_state_e;

    typedef enum logic [1:0] {
        FeedIdle,
        FeedStart,
        FeedWait
    } feed_state_e;

    localparam logic [15:0] MODBUS_CRC_RESIDUE = 16'h0000;
    localparam logic [7:0]  MODBUS_BROADCAST   = 8'h00;
    localparam int unsigned MODBUS_MIN_FRAME   = 4;

    function automatic logic addr_match(input logic [7:0] byte0, input logic [7:0] own_addr);
        return (byte0 == own_addr) || (byte0 == MODBUS_BROADCAST);
    endfunction

endpackage

// File: rtl/modbus_frame_ram.sv
// Frame byte buffer: one write port, two registered read ports (CRC feeder and host).
module modbus_frame_ram
    import modbus_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 256,
    parameter int unsigned AW        = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_fd_en,
    input  logic [AW-1:0] i_fd_addr,
    output logic [7:0]    o_fd_data,
    input  logic [AW-1:0] i_hs_addr,
    output logic [7:0]    o_hs_data
);

    logic [7:0] r_mem [MAX_BYTES];
    logic [7:0] r_fd_data;
    logic [7:0] r_hs_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Feeder port only loads when a byte is launched so o_crc_data stays put otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fd_data <= '0;
            r_hs_data <= '0;
        end else begin
            if (i_fd_en) begin
                r_fd_data <= r_mem[i_fd_addr];
            end
            r_hs_data <= r_mem[i_hs_addr];
        end
    end

    assign o_fd_data = r_fd_data;
    assign o_hs_data = r_hs_data;

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: buffers bytes, closes frames on t3.5 silence and streams them through
// the external CRC16 engine. Define MODBUS_ADDR_FILTER_EN to discard frames for other stations.
module modbus_rtu_rx_framer
    import modbus_pkg::*;
#(
    parameter int unsigned T35_CYCLES = 1750,
    parameter int unsigned MAX_BYTES  = 256,
    parameter int unsigned AW         = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_data,
    output logic          o_crc_rst,
    output logic          o_crc_enable,
    output logic          o_crc_start,
    output logic [7:0]    o_crc_data,
    input  logic [15:0]   i_crc16,
    input  logic          i_crc_done,
    input  logic [7:0]    i_slave_addr,
    output logic          o_frame_valid,
    output logic [AW:0]   o_frame_len,
    output logic          o_crc_ok,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    input  logic          i_frame_ack,
`ifdef MODBUS_ADDR_FILTER_EN
    output logic          o_broadcast,
`endif
    output logic          o_err_overrun
);

    localparam int unsigned TW = $clog2(T35_CYCLES) + 1;
    localparam logic [AW:0] LP_FULL = (AW+1)'(MAX_BYTES);

    rx_state_e   r_state;
    feed_state_e r_fstate;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [TW-1:0] r_timer;
    logic          r_overflow;
    logic [7:0]    r_byte0;
    logic          r_crc_start;
    logic          r_frame_valid;
    logic [AW:0]   r_frame_len;
    logic          r_crc_ok;
    logic          r_err_overrun;

    logic w_we;
    logic w_full;
    logic w_timeout;
    logic w_feed_go;
    logic w_drained;
    logic w_keep;
    logic w_release;

    assign w_full    = (r_wr_ptr == LP_FULL);
    assign w_timeout = (r_timer == TW'(T35_CYCLES - 1));
    assign w_drained = (r_fstate == FeedIdle) && (r_rd_ptr == r_wr_ptr);

    // CRC engine reset coincides with the first byte so the feeder can start right after it.
    assign o_crc_rst = !i_rst && i_rx_valid && (r_state == StIdle);

    assign w_we = !i_rst && i_rx_valid &&
                  ((r_state == StIdle) || ((r_state == StRecv) && !w_full));

    assign w_feed_go = (r_fstate == FeedIdle) && (r_rd_ptr != r_wr_ptr) && !o_crc_rst;

`ifdef MODBUS_ADDR_FILTER_EN
    logic r_broadcast;
    assign w_keep      = addr_match(r_byte0, i_slave_addr);
    assign o_broadcast = r_broadcast;
`else
    logic w_unused;
    assign w_keep   = 1'b1;
    assign w_unused = ^{i_slave_addr, r_byte0};
`endif

    // Buffer is re-armed either on host release or when a foreign frame is discarded.
    assign w_release = ((r_state == StHold) && i_frame_ack) ||
                       ((r_state == StDrain) && w_drained && !w_keep);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_wr_ptr      <= '0;
            r_timer       <= '0;
            r_overflow    <= 1'b0;
            r_byte0       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_len   <= '0;
            r_crc_ok      <= 1'b0;
            r_err_overrun <= 1'b0;
`ifdef MODBUS_ADDR_FILTER_EN
            r_broadcast   <= 1'b0;
`endif
        end else begin
            r_err_overrun <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_rx_valid) begin
                        r_byte0    <= i_rx_data;
                        r_wr_ptr   <= (AW+1)'(1);
                        r_timer    <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= StRecv;
                    end
                end
                StRecv: begin
                    // Any line activity, even a dropped byte, restarts the silence timer.
                    if (i_rx_valid) begin
                        r_timer <= '0;
                        if (w_full) begin
                            r_overflow    <= 1'b1;
                            r_err_overrun <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                        end
                    end else if (w_timeout) begin
                        r_state <= StDrain;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StDrain: begin
                    r_err_overrun <= i_rx_valid;
                    if (w_drained) begin
                        if (w_keep) begin
                            r_frame_valid <= 1'b1;
                            r_frame_len   <= r_wr_ptr;
                            r_crc_ok      <= (i_crc16 == MODBUS_CRC_RESIDUE) &&
                                             (r_wr_ptr >= (AW+1)'(MODBUS_MIN_FRAME)) &&
                                             !r_overflow;
`ifdef MODBUS_ADDR_FILTER_EN
                            r_broadcast   <= (r_byte0 == MODBUS_BROADCAST);
`endif
                            r_state       <= StHold;
                        end else begin
                            r_wr_ptr <= '0;
                            r_state  <= StIdle;
                        end
                    end
                end
                StHold: begin
                    r_err_overrun <= i_rx_valid;
                    if (i_frame_ack) begin
                        r_frame_valid <= 1'b0;
                        r_wr_ptr      <= '0;
                        r_state       <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_release) begin
            r_fstate    <= FeedIdle;
            r_rd_ptr    <= '0;
            r_crc_start <= 1'b0;
        end else begin
            r_crc_start <= 1'b0;
            unique case (r_fstate)
                FeedIdle: begin
                    if (w_feed_go) begin
                        r_crc_start <= 1'b1;
                        r_fstate    <= FeedStart;
                    end
                end
                FeedStart: r_fstate <= FeedWait;
                FeedWait: begin
                    if (i_crc_done) begin
                        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                        r_fstate <= FeedIdle;
                    end
                end
                default: r_fstate <= FeedIdle;
            endcase
        end
    end

    modbus_frame_ram #(
        .MAX_BYTES (MAX_BYTES),
        .AW        (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_we),
        .i_waddr   (r_wr_ptr[AW-1:0]),
        .i_wdata   (i_rx_data),
        .i_fd_en   (w_feed_go),
        .i_fd_addr (r_rd_ptr[AW-1:0]),
        .o_fd_data (o_crc_data),
        .i_hs_addr (i_rd_addr),
        .o_hs_data (o_rd_data)
    );

    assign o_crc_enable  = 1'b1;
    assign o_crc_start   = r_crc_start;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_len   = r_frame_len;
    assign o_crc_ok      = r_crc_ok;
    assign o_err_overrun = r_err_overrun;

endmodule
